icache: RTL

Direct-mapped instruction cache between the pipeline's instruction memory bus and a slower backing memory port. It answers 64-bit aligned fetches with one-cycle latency on a hit. On a miss it runs a single-word line fill over a req/ack handshake. The pipeline connects directly to the imem_* side; the mem_* side goes to the system memory arbiter.

---
 rtl/icache_pkg.sv | 14 +
 rtl/icache_array.sv | 33 +++
 rtl/icache.sv | 99 +++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared Raisin64 widths and icache FSM state encoding
package icache_pkg;
  localparam int WORD_W      = 64;
  localparam int ADDR_W      = 64;
  localparam int OFFSET_BITS = 3;
  localparam int LINE_W      = ADDR_W - OFFSET_BITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_MISS   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;
endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - synchronous-read tag+data RAM with a single write port
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = LINE_W - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [WORD_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [WORD_W-1:0]     wr_data
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [WORD_W-1:0] data_mem [LINES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_idx];
      rd_data <= data_mem[rd_idx];
    end
  end
endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache, one-word lines, req/ack refill
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_addr_valid,
  output logic [WORD_W-1:0] imem_data,
  output logic              imem_data_valid,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata
);
  localparam int TAG_W = LINE_W - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  state_t                  state, next_state;
  logic [LINE_W-1:0]       req_line, line_q;
  logic [INDEX_BITS-1:0]   idx_q;
  logic [TAG_W-1:0]        tag_q, arr_tag;
  logic [WORD_W-1:0]       arr_data, fill_data_q;
  logic [LINES-1:0]        valid_q;
  logic                    flushed_q;
  logic                    hit, accept, fill;
  logic                    unused_offset;

  assign req_line      = imem_addr[ADDR_W-1:OFFSET_BITS];
  assign unused_offset = ^imem_addr[OFFSET_BITS-1:0];
  assign idx_q         = line_q[INDEX_BITS-1:0];
  assign tag_q         = line_q[LINE_W-1:INDEX_BITS];

  assign hit    = (state == ST_LOOKUP) && valid_q[idx_q] && (arr_tag == tag_q);
  assign accept = imem_addr_valid &&
                  ((state == ST_IDLE) || (state == ST_RESP) || hit);
  assign fill   = (state == ST_MISS) && mem_ack;

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk     (clk),
    .rd_en   (accept),
    .rd_idx  (req_line[INDEX_BITS-1:0]),
    .rd_tag  (arr_tag),
    .rd_data (arr_data),
    .wr_en   (fill),
    .wr_idx  (idx_q),
    .wr_tag  (tag_q),
    .wr_data (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = ST_LOOKUP;
      ST_LOOKUP: if (!hit)   next_state = ST_MISS;
                 else        next_state = accept ? ST_LOOKUP : ST_IDLE;
      ST_MISS:   if (mem_ack) next_state = ST_RESP;
      ST_RESP:   next_state = accept ? ST_LOOKUP : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_data_valid = hit || (state == ST_RESP);
    imem_data       = (state == ST_LOOKUP) ? arr_data : fill_data_q;
  end

  // flushed_q remembers a flush seen between accepting a request and its fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q      <= '0;
      flushed_q   <= 1'b0;
      fill_data_q <= '0;
      valid_q     <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
    end else begin
      if (accept) line_q <= req_line;
      if (accept)     flushed_q <= 1'b0;
      else if (flush) flushed_q <= 1'b1;
      if (fill) fill_data_q <= mem_rdata;
      if (flush)                  valid_q <= '0;
      else if (fill && !flushed_q) valid_q[idx_q] <= 1'b1;
      mem_req <= (next_state == ST_MISS);
      if ((state == ST_LOOKUP) && !hit) mem_addr <= {line_q, {OFFSET_BITS{1'b0}}};
    end
  end
endmodule
